// File: rtl/bcd_disp_scan.sv
// ---------------------------------------------------------------------------
// bcd_disp_scan
//
// Multiplexed driver for a six-digit hh.mm.ss seven-segment display. Each
// digit gets one lit cycle (SHOW) followed by one blank cycle (DEAD), giving
// a 12-cycle frame. The time digits are captured once per frame so a digit
// that changes mid-frame never produces a torn display.
//
// Optional feature: define DISP_BLINK_EN to blink the hours/minutes digits
// while the timekeeper's edit flag is high. Without it, edit is ignored.
//
// Parameters
//   BLINK_HALF  clk_1kHz cycles per blink half-period.
//
// Ports
//   clk_1kHz  in   scan clock, rising edge
//   resetn    in   asynchronous, active-low reset
//   mode      in   [1:0] display owner; 2'b00 / 2'b01 are clock modes
//   edit      in   clock-edit flag (used only with DISP_BLINK_EN)
//   h1..s0    in   [3:0] BCD time digits
//   an        out  [7:0] anode enables, active-low, an[0] rightmost
//   seg       out  [6:0] segments {g,f,e,d,c,b,a}, active-low
//   dp        out  decimal point, active-low
// ---------------------------------------------------------------------------
module bcd_disp_scan #(
    parameter int BLINK_HALF = 250
) (
    input  logic       clk_1kHz,
    input  logic       resetn,
    input  logic [1:0] mode,
    input  logic       edit,
    input  logic [3:0] h1,
    input  logic [3:0] h0,
    input  logic [3:0] m1,
    input  logic [3:0] m0,
    input  logic [3:0] s1,
    input  logic [3:0] s0,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    typedef enum logic {SHOW = 1'b0, DEAD = 1'b1} phase_e;

    phase_e          phase_q, phase_d;
    logic [2:0]      idx_q, idx_d;
    // Snapshot of digits idx1..idx5; idx0 is always taken live at frame start.
    logic [5:1][3:0] snap_q, snap_d;
    logic [7:0]      an_q, an_d;
    logic [6:0]      seg_q, seg_d;
    logic            dp_q, dp_d;
    logic [3:0]      digit;
    logic            blink_blank;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'h40;
            4'd1:    seg_decode = 7'h79;
            4'd2:    seg_decode = 7'h24;
            4'd3:    seg_decode = 7'h30;
            4'd4:    seg_decode = 7'h19;
            4'd5:    seg_decode = 7'h12;
            4'd6:    seg_decode = 7'h02;
            4'd7:    seg_decode = 7'h78;
            4'd8:    seg_decode = 7'h00;
            4'd9:    seg_decode = 7'h10;
            default: seg_decode = 7'h3F;   // non-BCD value shows a dash
        endcase
    endfunction

`ifdef DISP_BLINK_EN
    localparam int BW = (BLINK_HALF > 1) ? $clog2(2 * BLINK_HALF) : 1;

    logic [BW-1:0] blink_q, blink_d;

    always_comb begin
        blink_d = (blink_q == BW'(2 * BLINK_HALF - 1)) ? '0 : blink_q + 1'b1;
    end

    always_ff @(posedge clk_1kHz or negedge resetn) begin
        if (!resetn) begin
            blink_q <= '0;
        end else begin
            blink_q <= blink_d;
        end
    end

    // Blink decision uses the counter value that becomes current with the
    // outputs, so a displayed digit and its counter value always line up.
    always_comb begin
        blink_blank = edit && (blink_d >= BW'(BLINK_HALF)) && (idx_d <= 3'd3);
    end
`else
    logic unused_cfg;
    assign unused_cfg  = edit ^ (BLINK_HALF == 0);
    assign blink_blank = 1'b0;
`endif

    // Next scan state, snapshot and the outputs for the state being entered.
    always_comb begin
        phase_d = (phase_q == SHOW) ? DEAD : SHOW;
        if (phase_q == SHOW) begin
            idx_d = idx_q;
        end else begin
            idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
        end

        snap_d = snap_q;
        if (phase_d == SHOW && idx_d == 3'd0) begin
            snap_d = {s0, s1, m0, m1, h0};
        end

        case (idx_d)
            3'd1:    digit = snap_q[1];
            3'd2:    digit = snap_q[2];
            3'd3:    digit = snap_q[3];
            3'd4:    digit = snap_q[4];
            3'd5:    digit = snap_q[5];
            default: digit = h1;
        endcase

        an_d  = 8'hFF;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        if (phase_d == SHOW && !mode[1]) begin
            dp_d = !(idx_d == 3'd1 || idx_d == 3'd3);
            // Leading-zero blanking of the tens-of-hours digit.
            if (!(idx_d == 3'd0 && h1 == 4'd0) && !blink_blank) begin
                for (int i = 0; i < 6; i++) begin
                    if (idx_d == 3'(5 - i)) begin
                        an_d[i] = 1'b0;
                    end
                end
                seg_d = seg_decode(digit);
            end
        end
    end

    always_ff @(posedge clk_1kHz or negedge resetn) begin
        if (!resetn) begin
            phase_q <= DEAD;
            idx_q   <= 3'd5;
            snap_q  <= '0;
            an_q    <= 8'hFF;
            seg_q   <= 7'h7F;
            dp_q    <= 1'b1;
        end else begin
            phase_q <= phase_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_bcd_disp_scan.sv
// ---------------------------------------------------------------------------
// tb_bcd_disp_scan
//
// Directed bench for bcd_disp_scan: reset values, a full 12:34:56 frame,
// snapshot behaviour across a mid-frame digit change, leading-zero blanking,
// dash decode, non-clock mode, mid-frame reset and (with DISP_BLINK_EN)
// hh/mm blinking while edit is high.
// ---------------------------------------------------------------------------
module tb_bcd_disp_scan;

    logic       clk_1kHz;
    logic       resetn;
    logic [1:0] mode;
    logic       edit;
    logic [3:0] h1, h0, m1, m0, s1, s0;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;

    int errors;
    int checks;
    int ecnt;   // expected blink counter value, period 8

    bcd_disp_scan #(.BLINK_HALF(4)) dut (
        .clk_1kHz (clk_1kHz),
        .resetn   (resetn),
        .mode     (mode),
        .edit     (edit),
        .h1       (h1),
        .h0       (h0),
        .m1       (m1),
        .m0       (m0),
        .s1       (s1),
        .s0       (s0),
        .an       (an),
        .seg      (seg),
        .dp       (dp)
    );

    initial clk_1kHz = 1'b0;
    always #5 clk_1kHz = ~clk_1kHz;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    // Advance one clock and compare the registered outputs on the falling edge.
    task automatic cyc(input string tag, input logic [7:0] ean, input logic [6:0] eseg,
                       input logic edp, input bit hhmm);
        logic [7:0] a;
        logic [6:0] s;
        a = ean;
        s = eseg;
        @(negedge clk_1kHz);
        ecnt = (ecnt + 1) % 8;
`ifdef DISP_BLINK_EN
        if (edit && hhmm && ecnt >= 4) begin
            a = 8'hFF;
            s = 7'h7F;
        end
`else
        if (hhmm) begin
            a = ean;
        end
`endif
        check({tag, " an"}, an, a);
        check({tag, " seg"}, {1'b0, seg}, {1'b0, s});
        check({tag, " dp"}, {7'b0, dp}, {7'b0, edp});
    endtask

    task automatic dead(input string tag);
        cyc(tag, 8'hFF, 7'h7F, 1'b1, 1'b0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        ecnt   = 0;
        resetn = 1'b0;
        mode   = 2'b00;
        edit   = 1'b0;
        {h1, h0, m1, m0, s1, s0} = {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};

        #12;
        check("reset an", an, 8'hFF);
        check("reset seg", {1'b0, seg}, 8'h7F);
        check("reset dp", {7'b0, dp}, 8'h01);

        @(negedge clk_1kHz);
        resetn = 1'b1;

        // Frame 1: 12:34:56
        cyc("f1 show0", 8'hDF, 7'h79, 1'b1, 1'b1);
        dead("f1 dead0");
        cyc("f1 show1", 8'hEF, 7'h24, 1'b0, 1'b1);
        dead("f1 dead1");
        cyc("f1 show2", 8'hF7, 7'h30, 1'b1, 1'b1);
        dead("f1 dead2");
        cyc("f1 show3", 8'hFB, 7'h19, 1'b0, 1'b1);
        dead("f1 dead3");
        cyc("f1 show4", 8'hFD, 7'h12, 1'b1, 1'b0);
        dead("f1 dead4");
        cyc("f1 show5", 8'hFE, 7'h02, 1'b1, 1'b0);
        dead("f1 dead5");

        // Frame 2: digits change during SHOW(2); rest of frame keeps snapshot
        cyc("f2 show0", 8'hDF, 7'h79, 1'b1, 1'b1);
        dead("f2 dead0");
        cyc("f2 show1", 8'hEF, 7'h24, 1'b0, 1'b1);
        dead("f2 dead1");
        cyc("f2 show2", 8'hF7, 7'h30, 1'b1, 1'b1);
        m0 = 4'd5;
        h1 = 4'd0;
        h0 = 4'd9;
        s0 = 4'hC;
        dead("f2 dead2");
        cyc("f2 show3 old m0", 8'hFB, 7'h19, 1'b0, 1'b1);
        dead("f2 dead3");
        cyc("f2 show4", 8'hFD, 7'h12, 1'b1, 1'b0);
        dead("f2 dead4");
        cyc("f2 show5 old s0", 8'hFE, 7'h02, 1'b1, 1'b0);
        dead("f2 dead5");

        // Frame 3: 09:35:5C -> leading zero blanked, dash on s0
        cyc("f3 show0 blank", 8'hFF, 7'h7F, 1'b1, 1'b1);
        dead("f3 dead0");
        cyc("f3 show1", 8'hEF, 7'h10, 1'b0, 1'b1);
        dead("f3 dead1");
        cyc("f3 show2", 8'hF7, 7'h30, 1'b1, 1'b1);
        dead("f3 dead2");
        cyc("f3 show3 new m0", 8'hFB, 7'h12, 1'b0, 1'b1);
        dead("f3 dead3");
        cyc("f3 show4", 8'hFD, 7'h12, 1'b1, 1'b0);
        dead("f3 dead4");
        cyc("f3 show5 dash", 8'hFE, 7'h3F, 1'b1, 1'b0);
        dead("f3 dead5");

        // Frame 4: display owned by another mode, everything dark
        mode = 2'b10;
        for (int i = 0; i < 12; i++) begin
            cyc($sformatf("f4 mode10 c%0d", i), 8'hFF, 7'h7F, 1'b1, 1'b0);
        end

        // Frame 5: back to clock mode, edit raised, h1 now live 2
        mode = 2'b00;
        h1   = 4'd2;
        edit = 1'b1;
        cyc("f5 show0", 8'hDF, 7'h24, 1'b1, 1'b1);
        dead("f5 dead0");
        cyc("f5 show1", 8'hEF, 7'h10, 1'b0, 1'b1);
        dead("f5 dead1");
        cyc("f5 show2", 8'hF7, 7'h30, 1'b1, 1'b1);
        dead("f5 dead2");
        cyc("f5 show3", 8'hFB, 7'h12, 1'b0, 1'b1);

        // Asynchronous reset in SHOW(3)
        resetn = 1'b0;
        ecnt   = 0;
        #2;
        check("midrst an", an, 8'hFF);
        check("midrst seg", {1'b0, seg}, 8'h7F);
        check("midrst dp", {7'b0, dp}, 8'h01);
        @(posedge clk_1kHz);
        #1;
        check("midrst held an", an, 8'hFF);
        @(negedge clk_1kHz);
        resetn = 1'b1;

        // Two frames after reset, edit still high
        for (int f = 0; f < 2; f++) begin
            cyc($sformatf("f%0d show0", 6 + f), 8'hDF, 7'h24, 1'b1, 1'b1);
            dead("r dead0");
            cyc($sformatf("f%0d show1", 6 + f), 8'hEF, 7'h10, 1'b0, 1'b1);
            dead("r dead1");
            cyc($sformatf("f%0d show2", 6 + f), 8'hF7, 7'h30, 1'b1, 1'b1);
            dead("r dead2");
            cyc($sformatf("f%0d show3", 6 + f), 8'hFB, 7'h12, 1'b0, 1'b1);
            dead("r dead3");
            cyc($sformatf("f%0d show4", 6 + f), 8'hFD, 7'h12, 1'b1, 1'b0);
            dead("r dead4");
            cyc($sformatf("f%0d show5", 6 + f), 8'hFE, 7'h3F, 1'b1, 1'b0);
            dead("r dead5");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
